// File: rtl/truth_table_sequencer.sv
// Walks a 4-input function unit through all 16 vectors and checks the captured truth table against an expected one.
// Latency: each vector is held for SETTLE+1 cycles; done pulses one cycle after vector 15 is sampled.
// Backpressure: none; start is accepted only in IDLE and is dropped otherwise, and abort cancels a running sweep.
module truth_table_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  fail_count,
    output logic [3:0]  fail_idx
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] exp_q;
    logic        accept;
    logic        sample;
    logic        mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Abort wins over a sample landing in the same cycle.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == SETTLE_C) begin
                    sample = 1'b1;
                    if (idx == 4'd15) begin
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        mismatch = (f != exp_q[idx]);
    end

    // idx doubles as the registered vector; it returns to 0 whenever the sweep ends.
    assign {a, b, c, d} = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            cnt        <= 4'd0;
            exp_q      <= 16'd0;
            table_out  <= 16'd0;
            fail_count <= 5'd0;
            fail_idx   <= 4'd0;
            pass       <= 1'b0;
        end else if (accept) begin
            exp_q      <= expected;
            idx        <= 4'd0;
            cnt        <= 4'd0;
            table_out  <= 16'd0;
            fail_count <= 5'd0;
            fail_idx   <= 4'd0;
            pass       <= 1'b0;
        end else if (state == RUN) begin
            if (abort) begin
                idx  <= 4'd0;
                cnt  <= 4'd0;
                pass <= 1'b0;
            end else if (sample) begin
                table_out[idx] <= f;
                if (mismatch) begin
                    fail_count <= fail_count + 5'd1;
                    if (fail_count == 5'd0) begin
                        fail_idx <= idx;
                    end
                end
                cnt <= 4'd0;
                idx <= idx + 4'd1;
                // pass must be valid in the done cycle, so fold in the final vector here.
                if (idx == 4'd15) begin
                    pass <= (fail_count == 5'd0) && !mismatch;
                end
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: directed vector table, multi-cycle corner sequences and randomized sweeps vs a reference model.
module tb_truth_table_sequencer;

    localparam int S     = 2;
    localparam int SWEEP = 16 * (S + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'd0;
    logic        a, b, c, d, f;
    logic        busy, done, pass;
    logic [15:0] table_out;
    logic [4:0]  fail_count;
    logic [3:0]  fail_idx;
    logic [15:0] fu_tt = 16'd0;
    logic [31:0] all_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Function unit: arbitrary 4-input function given by its own truth table.
    assign f = fu_tt[{a, b, c, d}];
    assign all_out = {a, b, c, d, busy, done, pass, table_out, fail_count, fail_idx};

    truth_table_sequencer #(.SETTLE(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .expected   (expected),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .f          (f),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .table_out  (table_out),
        .fail_count (fail_count),
        .fail_idx   (fail_idx)
    );

    typedef struct {
        string       name;
        logic [15:0] fu;
        logic [15:0] ex;
        logic [15:0] tab;
        logic [4:0]  cnt;
        logic [3:0]  fidx;
        logic        ps;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: outcome of a sweep over the vectors selected by mask.
    function automatic void model(input logic [15:0] fu, input logic [15:0] ex, input logic [15:0] mask,
                                  output logic [15:0] tab, output logic [4:0] cnt,
                                  output logic [3:0] fidx, output logic ps);
        logic [15:0] mism;
        mism = (fu ^ ex) & mask;
        tab  = fu & mask;
        cnt  = 5'($countones(mism));
        fidx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mism[i]) fidx = 4'(i);
        end
        ps = (mism == 16'd0);
    endfunction

    task automatic check_results(input string name, input logic [15:0] tab, input logic [4:0] cnt,
                                 input logic [3:0] fidx, input logic ps);
        chk({name, "_table"}, 32'(table_out), 32'(tab));
        chk({name, "_count"}, 32'(fail_count), 32'(cnt));
        chk({name, "_pass"}, 32'(pass), 32'(ps));
        if (!ps) chk({name, "_fidx"}, 32'(fail_idx), 32'(fidx));
    endtask

    // Full sweep; optional second start at cycle restart_at and abort alongside the accepted start.
    task automatic sweep(input string name, input logic [15:0] fu, input logic [15:0] ex,
                         input int restart_at, input logic [15:0] ex2, input logic ab0,
                         input logic [15:0] tab, input logic [4:0] cnt, input logic [3:0] fidx,
                         input logic ps);
        int k;
        int vec_err;
        fu_tt = fu;
        @(negedge clk);
        expected = ex;
        start    = 1'b1;
        abort    = ab0;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        expected = ~ex;
        k        = 0;
        vec_err  = 0;
        while (done !== 1'b1 && k < SWEEP + 10) begin
            if ({a, b, c, d} !== 4'(k / (S + 1)) || busy !== 1'b1) vec_err++;
            if (k == restart_at) begin
                start    = 1'b1;
                expected = ex2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({name, "_vec_seq"}, 32'(vec_err), 32'd0);
        chk({name, "_done_cycle"}, 32'(k), 32'(SWEEP));
        chk({name, "_finish_busy"}, 32'(busy), 32'd0);
        chk({name, "_finish_vec"}, 32'({a, b, c, d}), 32'd0);
        check_results(name, tab, cnt, fidx, ps);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_pass_hold"}, 32'(pass), 32'(ps));
    endtask

    initial begin
        logic [15:0] tab, fu, ex;
        logic [4:0]  cnt;
        logic [3:0]  fidx;
        logic        ps;
        int          extra;

        vecs[0] = '{"parity",    16'h6996, 16'h6996, 16'h6996, 5'd0,  4'd0,  1'b1};
        vecs[1] = '{"single",    16'h6996, 16'h69B6, 16'h6996, 5'd1,  4'd5,  1'b0};
        vecs[2] = '{"stuck0",    16'h0000, 16'h6996, 16'h0000, 5'd8,  4'd1,  1'b0};
        vecs[3] = '{"all_fail",  16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 4'd0,  1'b0};
        vecs[4] = '{"last_fail", 16'h8000, 16'h0000, 16'h8000, 5'd1,  4'd15, 1'b0};

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            sweep(vecs[i].name, vecs[i].fu, vecs[i].ex, -1, 16'd0, 1'b0,
                  vecs[i].tab, vecs[i].cnt, vecs[i].fidx, vecs[i].ps);
        end

        // Start while busy is dropped: results follow the first request, single done.
        sweep("busy_start", 16'h6996, 16'h6996, 10, 16'h0000, 1'b0, 16'h6996, 5'd0, 4'd0, 1'b1);
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("busy_start_extra_done", 32'(extra), 32'd0);
        chk("busy_start_hold_table", 32'(table_out), 32'h6996);

        // Abort sampled at edge 20: vectors 0..5 captured, then idle with no done.
        fu = 16'h6996;
        ex = 16'h0F0F;
        fu_tt = fu;
        @(negedge clk);
        expected = ex;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        model(fu, ex, 16'h003F, tab, cnt, fidx, ps);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_vec", 32'({a, b, c, d}), 32'd0);
        check_results("abort", tab, cnt, fidx, 1'b0);
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("abort_no_done", 32'(extra), 32'd0);
        chk("abort_hold_table", 32'(table_out), 32'(tab));

        // Fresh start after abort, with abort raised alongside start (start wins).
        sweep("after_abort", 16'h6996, 16'h6996, -1, 16'd0, 1'b1, 16'h6996, 5'd0, 4'd0, 1'b1);

        // Reset mid-sweep clears everything at once.
        fu_tt = 16'h6996;
        @(negedge clk);
        expected = 16'h0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_outputs", all_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("midrst_quiet", 32'(extra), 32'd0);
        sweep("after_rst", 16'h6996, 16'h69B6, -1, 16'd0, 1'b0, 16'h6996, 5'd1, 4'd5, 1'b0);

        for (int i = 0; i < 20; i++) begin
            fu = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ex = fu;
            else ex = fu ^ 16'($urandom & $urandom & $urandom);
            model(fu, ex, 16'hFFFF, tab, cnt, fidx, ps);
            sweep($sformatf("rand%0d", i), fu, ex, -1, 16'd0, 1'b0, tab, cnt, fidx, ps);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that drives a 4-input combinational function unit (inputs a, b, c, d; output f) through all 16 input vectors. It captures f for each vector into a 16-bit truth table and compares it against an expected table. It sits between the function unit and a host or self-test harness, and replaces a hand-written vector sweep with a start/done handshake and a pass/fail summary.

## Interface
- SETTLE, default 2: extra wait cycles per vector before f is sampled. Legal range 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request a sweep. Accepted only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected  input  16  expected truth table. Bit i is the f value for vector i. Latched when start is accepted.
- a, b, c, d  output  1 each  registered vector to the function unit. {a,b,c,d} = idx, with a as MSB.
- f  input  1  function unit output.
- busy  output  1  high from the cycle after start is accepted until done or abort.
- done  output  1  one-cycle pulse when a sweep completes. Not asserted on abort.
- pass  output  1  high when the last completed sweep had zero mismatches.
- table_out  output  16  captured f values, with bit i for vector i.
- fail_count  output  5  number of mismatching vectors (0..16).
- fail_idx  output  4  index of the first mismatching vector. Meaningful only when pass=0.

## Operation
- States: IDLE, RUN, FINISH.
- **IDLE**
  - a..d = 0, busy = 0.
  - start=1: latch expected, idx←0, cnt←0, table_out←0, fail_count←0, fail_idx←0, pass←0, go to RUN.
- **RUN**
  - {a,b,c,d} = idx.
  - cnt counts 0..SETTLE. At cnt==SETTLE the block samples f:
    - table_out[idx]←f.
    - If f≠expected[idx]: fail_count+1. If this is the first mismatch, fail_idx←idx.
    - cnt←0.
    - If idx==15, go to FINISH. Otherwise idx←idx+1.
  - Vector i therefore occupies exactly SETTLE+1 cycles.
- **FINISH**
  - One cycle: done=1, pass=(fail_count==0), busy=0.
  - a..d return to 0.
  - Next state is IDLE.
- abort=1 in RUN:
  - Next state is IDLE. No done pulse, pass←0.
  - table_out and fail_count keep their partial values.
- abort in IDLE or FINISH is ignored.
- start is ignored in RUN and FINISH. It is not queued.
- If start and abort are high together in IDLE, start wins.
- Results (table_out, pass, fail_count, fail_idx) hold until the next accepted start.
- fail_count saturation is unnecessary: the maximum is 16, which fits in 5 bits.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE and every output = 0 (a, b, c, d, busy, done, pass, table_out, fail_count, fail_idx). Internal idx, cnt and the latched expected also clear.
- Reset asserted mid-sweep clears immediately. No done pulse is produced.
- Sweep timing:
  - start sampled high at edge 0.
  - busy=1 and vector 0 are on a..d from edge 0 to edge 1.
  - Vector i is sampled at edge (i+1)(SETTLE+1).
  - done=1 in the cycle after edge 16(SETTLE+1), i.e. edge 49 with SETTLE=2.
- f is sampled in the same cycle the registered vector has been stable for SETTLE+1 cycles. The function unit must settle in that time. With SETTLE=0, it must settle within one cycle.
- pass and done become valid together. pass is stable from the done cycle onward.
- A new start is accepted in the cycle after done at the earliest. Back-to-back sweeps are therefore separated by one IDLE cycle.

## Test plan
- **Parity match:** f=a^b^c^d, expected=16'h6996, SETTLE=2, pulse start → a..d step 0..15 every 3 cycles, done at cycle 49, pass=1, table_out=16'h6996, fail_count=0.
- **Single mismatch:** same function, expected=16'h69B6 (bit 5 flipped) → pass=0, fail_count=1, fail_idx=5, table_out=16'h6996.
- **Stuck-at-0:** f tied 0, expected=16'h6996 → table_out=0, fail_count=8, fail_idx=1, pass=0.
- **Start while busy:** pulse start again at cycle 10 with a different expected → ignored, results match the first request, exactly one done pulse.
- **Abort:** abort at cycle 20 (SETTLE=2) → IDLE next cycle, busy=0, no done, pass=0, table_out holds vectors 0..5. A fresh start then completes normally.
- **Reset mid-sweep:** rst_n low asynchronously at cycle 15 → all outputs 0 immediately. After release, start runs a full sweep with done at relative cycle 49.
